// File: rtl/fetchq_pkg.sv
// Shared constants for the fetch queue: default depth, the NOP word shown
// while the queue presents nothing, and the pointer-width helper.
package fetchq_pkg;

   localparam int FETCHQ_DEPTH_DEF = 4;
   localparam logic [31:0] FETCHQ_NOP = 32'h0000_0000;

   function automatic int fetchq_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetchq_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fetchq_mem
   import fetchq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int DEPTH  = FETCHQ_DEPTH_DEF,
   parameter int AW     = fetchq_ptr_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_instr,
   input  logic [PC_W-1:0]   i_wr_pc,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_instr,
   output logic [PC_W-1:0]   o_rd_pc
);

   logic [DATA_W+PC_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= {i_wr_instr, i_wr_pc};
   end

   assign {o_rd_instr, o_rd_pc} = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through fetch queue between fetch and decode.
// Define FETCHQ_BYPASS_EN to let an empty queue present the incoming entry in the same cycle.
module fetch_queue
   import fetchq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int DEPTH  = FETCHQ_DEPTH_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [DATA_W-1:0]    i_instr,
   input  logic [PC_W-1:0]      i_pc,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [DATA_W-1:0]    o_instr,
   output logic [PC_W-1:0]      o_pc,
   input  logic                 i_ready,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = fetchq_ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_empty;
   logic              w_full;
   logic              w_bypass;
   logic              w_bypass_take;
   logic              w_out_valid;
   logic              w_push;
   logic              w_pop;
   logic              w_wr_en;
   logic              w_rd_en;
   logic [DATA_W-1:0] w_mem_instr;
   logic [PC_W-1:0]   w_mem_pc;
   logic [DATA_W-1:0] w_head_instr;
   logic [PC_W-1:0]   w_head_pc;

   fetchq_mem #(
      .DATA_W (DATA_W),
      .PC_W   (PC_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .i_clk      (i_clk),
      .i_wr_en    (w_wr_en),
      .i_wr_addr  (r_wr_ptr),
      .i_wr_instr (i_instr),
      .i_wr_pc    (i_pc),
      .i_rd_addr  (r_rd_ptr),
      .o_rd_instr (w_mem_instr),
      .o_rd_pc    (w_mem_pc)
   );

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
   // Reset gates the bypass so outputs read as idle while i_rst_n is low.
   assign w_bypass     = w_empty && i_valid && !i_flush && i_rst_n;
   assign w_head_instr = w_empty ? i_instr : w_mem_instr;
   assign w_head_pc    = w_empty ? i_pc    : w_mem_pc;
`else
   assign w_bypass     = 1'b0;
   assign w_head_instr = w_mem_instr;
   assign w_head_pc    = w_mem_pc;
`endif

   assign w_out_valid   = (!w_empty || w_bypass) && !i_flush;
   assign w_push        = i_valid && !w_full && !i_flush;
   assign w_pop         = w_out_valid && i_ready;
   // A bypassed entry consumed in the same cycle never touches storage.
   assign w_bypass_take = w_bypass && i_ready;
   assign w_wr_en       = w_push && !w_bypass_take;
   assign w_rd_en       = w_pop && !w_bypass_take;

   assign o_ready = !w_full;
   assign o_valid = w_out_valid;
   assign o_instr = w_out_valid ? w_head_instr : DATA_W'(FETCHQ_NOP);
   assign o_pc    = w_out_valid ? w_head_pc : '0;
   assign o_count = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, >=2.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port i_flush, input, 1, meaning discard all entries; driven by the branch/jump taken (pcsrc).
REQ-007 SHALL have port i_valid, input, 1, meaning the fetch stage offers an entry.
REQ-008 SHALL have port i_instr, input, DATA_W, meaning the fetched instruction.
REQ-009 SHALL have port i_pc, input, PC_W, meaning the PC of the fetched instruction.
REQ-010 SHALL have port o_ready, output, 1, meaning the queue accepts a push (drives fetch pcWrite).
REQ-011 SHALL have port o_valid, output, 1, meaning the head entry is presented to decode.
REQ-012 SHALL have port o_instr, output, DATA_W, meaning the head instruction.
REQ-013 SHALL have port o_pc, output, PC_W, meaning the head PC.
REQ-014 SHALL have port i_ready, input, 1, meaning decode consumes the head (low = hazard stall/bubble).
REQ-015 SHALL have port o_count, output, log2(DEPTH)+1, meaning current occupancy.

Function
REQ-016 Push SHALL occur when i_valid && o_ready && !i_flush.
REQ-017 Pop SHALL occur when o_valid && i_ready && !i_flush.
REQ-018 o_ready SHALL equal (o_count != DEPTH); a push offered while full is ignored even if a pop occurs that cycle.
REQ-019 Simultaneous push and pop SHALL leave o_count unchanged and advance both pointers.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or underflow.
REQ-021 Storage SHALL be first-word-fall-through: o_instr/o_pc show the oldest entry combinationally; push-to-o_valid latency is 1 cycle (base build).
REQ-022 Entries SHALL leave in push order, with no loss or duplication.
REQ-023 When i_flush is high, the next edge SHALL set o_count=0 and both pointers=0, and discard any same-cycle push.
REQ-024 o_valid SHALL be forced low combinationally while i_flush is high.
REQ-025 When o_valid is low, o_instr and o_pc SHALL be driven all-zero (MIPS NOP, PC 0).

Reset
REQ-026 Asserting i_rst_n low SHALL, asynchronously and immediately, set o_count=0, pointers=0, o_valid=0, o_ready=1, o_instr=0, o_pc=0.
REQ-027 Reset SHALL override flush and push/pop; storage contents need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL appear as the head.

Configuration
REQ-029 Macro FETCHQ_BYPASS_EN SHALL, when defined, make an empty queue with i_valid high and i_flush low drive o_valid=1, o_instr=i_instr, o_pc=i_pc in the same cycle.
REQ-030 With FETCHQ_BYPASS_EN defined, if i_ready is also high in that cycle, the entry SHALL be consumed without being written and o_count SHALL stay 0; otherwise it is pushed normally.
REQ-031 Without FETCHQ_BYPASS_EN, no combinational path from i_valid/i_instr/i_pc to o_valid/o_instr/o_pc SHALL exist.

Structure
REQ-032 Package fetchq_pkg SHALL hold the DEPTH default, the NOP constant (32'h0000_0000), and the pointer-width constant/function.
REQ-033 Storage SHALL be sub-module fetchq_mem (DEPTH x (DATA_W+PC_W) register array, one write port, one async read port); all control logic stays in fetch_queue.

Verification
REQ-034 Reset, then push 4 entries (pc 0x00, 0x04, 0x08, 0x0C) with i_ready=0 -> o_count=4, o_ready=0; a 5th push is ignored.
REQ-035 From full, set i_ready=1 and i_valid=1 with pc 0x10 -> pops in order 0x00..0x0C; 0x10 is accepted on the first cycle o_ready=1 and pops last.
REQ-036 With 3 entries, pulse i_flush while offering pc 0x40 -> o_valid=0 that cycle; next cycle o_count=0; 0x40 is never output.
REQ-037 Sustained push+pop for 10 cycles at count=2 -> o_count stays 2; pointers wrap past DEPTH; output order is preserved.
REQ-038 Assert i_rst_n low mid-stream at count=3 -> outputs go to reset values before the next edge; after release, a push of pc 0x80 is the head one cycle later.
REQ-039 With FETCHQ_BYPASS_EN, empty queue, i_valid=1, i_ready=1, pc 0x20 -> o_valid=1 and o_pc=0x20 in the same cycle, o_count stays 0; without the macro, o_valid rises one cycle later.
